// File: rtl/morse_decoder_if.sv
// Morse decoder signal bundle: serial input line plus decoded letter outputs.
interface morse_decoder_if;
    logic       DotDashIn;
    logic [2:0] Letter;
    logic       LetterValid;
    logic       Error;
    logic       Busy;

    // Line driver / result consumer side.
    modport master (
        output DotDashIn,
        input  Letter,
        input  LetterValid,
        input  Error,
        input  Busy
    );

    // Decoder side.
    modport slave (
        input  DotDashIn,
        output Letter,
        output LetterValid,
        output Error,
        output Busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder: aligns to the first rising edge of a 12-bit frame, samples each
// bit at its centre, and matches the frame against an 8-letter table (A..H).
module morse_decoder #(
    parameter int TICKS = 250
) (
    input  logic           ClockIn,
    input  logic           Resetn,
    morse_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(TICKS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [11:0]      frame_r, frame_next_s;
    logic [3:0]       bit_r, bit_next_s;
    logic             prev_in_r;
    logic [2:0]       letter_r, letter_next_s;
    logic             valid_r, valid_next_s;
    logic             error_r, error_next_s;
    logic             busy_r;
    logic             rise_s;
    logic [3:0]       match_s;

    // Table lookup: returns {hit, letter code}; hit=0 when no entry matches.
    function automatic logic [3:0] decode_frame(input logic [11:0] f);
        logic [3:0] r;
        case (f)
            12'b101110000000: r = {1'b1, 3'd0};
            12'b111010101000: r = {1'b1, 3'd1};
            12'b111010111010: r = {1'b1, 3'd2};
            12'b111010100000: r = {1'b1, 3'd3};
            12'b100000000000: r = {1'b1, 3'd4};
            12'b101011101000: r = {1'b1, 3'd5};
            12'b111011101000: r = {1'b1, 3'd6};
            12'b101010100000: r = {1'b1, 3'd7};
            default:          r = 4'b0000;
        endcase
        return r;
    endfunction

    assign rise_s  = bus.DotDashIn & ~prev_in_r;
    assign match_s = decode_frame(frame_r);

    // Next-state and datapath decisions; sample points fall where the tick counter hits zero.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        frame_next_s  = frame_r;
        bit_next_s    = bit_r;
        letter_next_s = letter_r;
        valid_next_s  = 1'b0;
        error_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    cnt_next_s   = HALF_LOAD;
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (cnt_r == '0) begin
                    if (bus.DotDashIn) begin
                        frame_next_s = 12'd1;
                        bit_next_s   = 4'd1;
                        cnt_next_s   = FULL_LOAD;
                        state_next_s = ST_SHIFT;
                    end else begin
                        // MSB low at its centre: the edge was a glitch.
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_r == '0) begin
                    // Reload rather than free-run so every sample is exactly TICKS apart.
                    frame_next_s = {frame_r[10:0], bus.DotDashIn};
                    cnt_next_s   = FULL_LOAD;
                    if (bit_r == 4'd11) begin
                        bit_next_s   = 4'd0;
                        state_next_s = ST_DECIDE;
                    end else begin
                        bit_next_s = bit_r + 4'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                if (match_s[3]) begin
                    letter_next_s = match_s[2:0];
                    valid_next_s  = 1'b1;
                end else begin
                    error_next_s = 1'b1;
                end
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers; prev_in_r tracks the line in every state.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            cnt_r     <= '0;
            frame_r   <= 12'd0;
            bit_r     <= 4'd0;
            prev_in_r <= 1'b0;
            letter_r  <= 3'd0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            frame_r   <= frame_next_s;
            bit_r     <= bit_next_s;
            prev_in_r <= bus.DotDashIn;
            letter_r  <= letter_next_s;
            valid_r   <= valid_next_s;
            error_r   <= error_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.Letter      = letter_r;
    assign bus.LetterValid = valid_r;
    assign bus.Error       = error_r;
    assign bus.Busy        = busy_r;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: timeline reference model compared every
// cycle, plus directed frames with hand-computed expectations and random frames.
module tb_morse_decoder;

    localparam int T = 250;
    localparam int H = T / 2;
    localparam logic [11:0] TABLE [8] = '{
        12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
        12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    morse_decoder_if bus();

    morse_decoder #(.TICKS(T)) dut (
        .ClockIn (clk),
        .Resetn  (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: expected outputs after the most recent rising edge
    int          m_active    = 0;
    int          m_e         = 0;
    int          m_decide_at = -1;
    logic        m_prev      = 1'b0;
    logic [11:0] m_frame     = 12'd0;
    int          exp_letter  = 0;
    int          exp_valid   = 0;
    int          exp_error   = 0;
    int          exp_busy    = 0;

    // observed pulses
    int p_cyc[$];
    int p_letter[$];
    int p_kind[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_pulse(input string name, input int idx, input int kind, input int letter);
        check({name, "_present"}, (p_cyc.size() > idx) ? 1 : 0, 1);
        if (p_cyc.size() > idx) begin
            check({name, "_kind"}, p_kind[idx], kind);
            check({name, "_letter"}, p_letter[idx], letter);
        end
    endtask

    // Model: frame timing derived from the edge cycle E (samples at E+H+k*T).
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                m_active = 0; m_prev = 1'b0; m_decide_at = -1;
                exp_letter = 0; exp_valid = 0; exp_error = 0; exp_busy = 0;
            end else begin
                exp_valid = 0;
                exp_error = 0;
                if (m_active != 0 && cyc == m_decide_at) begin
                    int found;
                    found = -1;
                    for (int i = 0; i < 8; i++)
                        if (TABLE[i] == m_frame) found = i;
                    if (found >= 0) begin
                        exp_letter = found;
                        exp_valid  = 1;
                    end else begin
                        exp_error = 1;
                    end
                    m_active = 0;
                    exp_busy = 0;
                end else if (m_active == 0) begin
                    if (bus.DotDashIn && !m_prev) begin
                        m_active = 1; m_e = cyc; m_decide_at = -1;
                        m_frame = 12'd0; exp_busy = 1;
                    end
                end else begin
                    int t;
                    t = cyc - m_e;
                    if (t >= H && ((t - H) % T) == 0) begin
                        m_frame = {m_frame[10:0], bus.DotDashIn};
                        if (t == H && !bus.DotDashIn) begin
                            m_active = 0;
                            exp_busy = 0;
                        end else if ((t - H) / T == 11) begin
                            m_decide_at = cyc + 1;
                        end
                    end
                end
                m_prev = bus.DotDashIn;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_letter", int'(bus.Letter), 0);
                check("rst_valid", int'(bus.LetterValid), 0);
                check("rst_error", int'(bus.Error), 0);
                check("rst_busy", int'(bus.Busy), 0);
            end else begin
                check("letter", int'(bus.Letter), exp_letter);
                check("valid", int'(bus.LetterValid), exp_valid);
                check("error", int'(bus.Error), exp_error);
                check("busy", int'(bus.Busy), exp_busy);
                check("valid_error_exclusive", int'(bus.LetterValid & bus.Error), 0);
                if (bus.LetterValid) begin
                    p_cyc.push_back(cyc); p_letter.push_back(int'(bus.Letter)); p_kind.push_back(0);
                end
                if (bus.Error) begin
                    p_cyc.push_back(cyc); p_letter.push_back(int'(bus.Letter)); p_kind.push_back(1);
                end
            end
        end
    end

    // Drive the first nbits bits of f, MSB first, each held T cycles; e = DUT edge of first bit.
    task automatic drive_bits(input logic [11:0] f, input int nbits, output int e);
        e = 0;
        for (int i = 11; i > 11 - nbits; i--) begin
            @(posedge clk); #1;
            if (i == 11) e = cyc + 1;
            bus.DotDashIn = f[i];
            repeat (T - 1) @(posedge clk);
        end
    endtask

    task automatic glitch(input int len);
        @(posedge clk); #1;
        bus.DotDashIn = 1'b1;
        repeat (len) @(posedge clk);
        #1 bus.DotDashIn = 1'b0;
    endtask

    initial begin
        int e, e1, e2, e3, n0, nb;
        int order [8];

        bus.DotDashIn = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.Busy), 0);
        check("reset_letter", int'(bus.Letter), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // A from idle: letter 0 with pulse at E+2876
        n0 = p_cyc.size();
        drive_bits(TABLE[0], 12, e);
        repeat (5) @(posedge clk); #1;
        check("A_count", p_cyc.size() - n0, 1);
        check_pulse("A", n0, 0, 0);
        if (p_cyc.size() > n0) check("A_latency", p_cyc[n0] - e, 2876);
        check("A_busy_after", int'(bus.Busy), 0);

        // C, E, H back to back: pulses 3000 cycles apart
        n0 = p_cyc.size();
        drive_bits(TABLE[2], 12, e1);
        drive_bits(TABLE[4], 12, e2);
        drive_bits(TABLE[7], 12, e3);
        repeat (5) @(posedge clk); #1;
        check("CEH_count", p_cyc.size() - n0, 3);
        check("CEH_edge_spacing", e3 - e1, 6000);
        check_pulse("C", n0, 0, 2);
        check_pulse("E", n0 + 1, 0, 4);
        check_pulse("H", n0 + 2, 0, 7);
        if (p_cyc.size() >= n0 + 3) begin
            check("CE_spacing", p_cyc[n0 + 1] - p_cyc[n0], 3000);
            check("EH_spacing", p_cyc[n0 + 2] - p_cyc[n0 + 1], 3000);
        end

        // unmatched frame: Error pulse, Letter stays at H
        n0 = p_cyc.size();
        drive_bits(12'b110000000000, 12, e);
        repeat (5) @(posedge clk); #1;
        check("ERR_count", p_cyc.size() - n0, 1);
        check_pulse("ERR", n0, 1, 7);
        check("ERR_letter_kept", int'(bus.Letter), 7);

        // 10-cycle glitch: no output, then G decodes
        n0 = p_cyc.size();
        glitch(10);
        repeat (200) @(posedge clk); #1;
        check("GLITCH_no_pulse", p_cyc.size() - n0, 0);
        check("GLITCH_busy", int'(bus.Busy), 0);
        drive_bits(TABLE[6], 12, e);
        repeat (5) @(posedge clk); #1;
        check_pulse("G", n0, 0, 6);

        // reset mid-B: immediate clear, no pulse, then D decodes
        nb = p_cyc.size();
        drive_bits(TABLE[1], 6, e);
        @(posedge clk); #1;
        check("B_busy_midframe", int'(bus.Busy), 1);
        bus.DotDashIn = 1'b0;
        rst_n = 1'b0;
        #1;
        check("B_rst_busy", int'(bus.Busy), 0);
        check("B_rst_letter", int'(bus.Letter), 0);
        check("B_rst_valid", int'(bus.LetterValid), 0);
        check("B_rst_error", int'(bus.Error), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3000) @(posedge clk); #1;
        check("B_no_pulse", p_cyc.size() - nb, 0);
        drive_bits(TABLE[3], 12, e);
        repeat (5) @(posedge clk); #1;
        check("D_count", p_cyc.size() - nb, 1);
        check_pulse("D", nb, 0, 3);

        // loop-back: every letter encoded from the table, shuffled order
        for (int i = 0; i < 8; i++) order[i] = i;
        for (int i = 7; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 8; i++) begin
            n0 = p_cyc.size();
            drive_bits(TABLE[order[i]], 12, e);
            repeat ($urandom_range(20, 1)) @(posedge clk);
            #1;
            check_pulse("LOOP", n0, 0, order[i]);
        end

        // random frames, noise and glitches checked by the model only
        for (int i = 0; i < 6; i++) begin
            int choice;
            logic [11:0] f;
            choice = $urandom_range(2, 0);
            if (choice == 0) begin
                drive_bits(TABLE[$urandom_range(7, 0)], 12, e);
            end else if (choice == 1) begin
                f = 12'($urandom);
                f[11] = 1'b1;
                drive_bits(f, 12, e);
            end else begin
                glitch($urandom_range(100, 1));
            end
            @(posedge clk); #1;
            bus.DotDashIn = 1'b0;
            repeat ($urandom_range(20, 1)) @(posedge clk);
        end

        repeat (300) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter TICKS, default 250, meaning ClockIn cycles per Morse symbol bit; even, >= 4.
REQ-002 SHALL have port ClockIn  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Resetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port DotDashIn  input  1  serial Morse line, synchronous to ClockIn; idle low; one bit per TICKS cycles.
REQ-005 SHALL have port Letter  output  3  code of last decoded letter (A=000 ... H=111).
REQ-006 SHALL have port LetterValid  output  1  one-cycle pulse: Letter was just updated with a valid decode.
REQ-007 SHALL have port Error  output  1  one-cycle pulse: 12-bit frame matched no table entry.
REQ-008 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL decode 12-bit frames, MSB first, against: A 101110000000, B 111010101000, C 111010111010, D 111010100000, E 100000000000, F 101011101000, G 111011101000, H 101010100000.
REQ-010 SHALL register DotDashIn into prevIn every cycle; a rising edge is DotDashIn=1 and prevIn=0.
REQ-011 SHALL implement states IDLE, ALIGN, SHIFT, DECIDE.
REQ-012 IDLE: on rising edge at clock edge E, load tick counter and go to ALIGN; otherwise stay.
REQ-013 ALIGN: count TICKS/2 cycles; at edge E+TICKS/2, sample DotDashIn as frame bit 11 (MSB).
REQ-014 If the MSB sample is 0, the decoder SHALL treat it as a glitch and return to IDLE with no LetterValid and no Error.
REQ-015 If the MSB sample is 1, the decoder SHALL go to SHIFT, with bit count = 1.
REQ-016 SHIFT: sample DotDashIn every TICKS cycles, shifting left into the 12-bit frame register; sample k is taken at edge E+TICKS/2+k*TICKS, for k=1..11.
REQ-017 After sample 11, the decoder SHALL enter DECIDE; rising edges on DotDashIn SHALL be ignored in ALIGN, SHIFT and DECIDE.
REQ-018 DECIDE (one cycle): compare the frame to the table. On a match, register Letter=code and LetterValid=1. With no match, leave Letter unchanged and register Error=1. Then return to IDLE.
REQ-019 LetterValid/Error SHALL be high exactly the cycle after the DECIDE edge, i.e. after edge E+TICKS/2+11*TICKS+1 (E+2876 for TICKS=250), and low otherwise.
REQ-020 LetterValid and Error SHALL never be high in the same cycle.
REQ-021 Back-to-back frames: a rising edge in the first cycle after returning to IDLE SHALL be detected. prevIn keeps tracking in all states, so a line held high across DECIDE is not treated as a new edge.
REQ-022 Tick counter width SHALL be ceil(log2(TICKS)); the counter SHALL reload on each sample without drift, giving exactly TICKS cycles between consecutive samples.

Reset
REQ-023 While Resetn=0, the block SHALL hold state=IDLE, Letter=000, LetterValid=0, Error=0, Busy=0, prevIn=0, frame=0, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait for a fresh rising edge and emit no output for the aborted frame.

Verification
REQ-025 TICKS=250: drive the A frame 101110000000 at 250 cycles/bit from idle -> Letter=000, LetterValid pulse 1 cycle at E+2876, Error=0, Busy low afterwards.
REQ-026 Drive the C, E and H frames back-to-back, with the next frame's rising edge immediately after the previous frame ends -> Letter=010, 100, 111 in order, three LetterValid pulses spaced 3000 cycles apart.
REQ-027 Drive frame 110000000000 -> Error pulse 1 cycle; Letter keeps its previous value; LetterValid=0.
REQ-028 Drive a 10-cycle high glitch on an idle line -> MSB sample 0, return to IDLE, no LetterValid/Error; a following valid G frame decodes to 110.
REQ-029 Assert Resetn=0 for 3 cycles mid-way through a B frame -> all outputs 0 immediately; no pulse for that frame; a subsequent D frame decodes to 011.
REQ-030 Loop-back test: feed the decoder from the team's Morse encoder (same clock, 250-cycle rate) for all 8 letters -> each decoded Letter equals the encoder's Letter input.
